// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg : shared types for the MIPS data-memory responder
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    // Access size as presented by the processor; encoding 3 is illegal.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/mips_dmem_array.sv
//------------------------------------------------------------------------------
// mips_dmem_array : single-port synchronous word storage, big-endian byte enables
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       byte_we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Enable bit 3 is byte 0, which lives in [31:24]; read returns pre-write data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/mips_data_mem.sv
//------------------------------------------------------------------------------
// mips_data_mem : fixed-latency data-memory responder for a MIPS core.
//                 MIPS_DMEM_SUBWORD_EN enables byte/halfword accesses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_data_mem
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        data_rd_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] data_in
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_e state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, fire;

    logic [31:0] offset, req_wdata;
    logic        in_range, bad_align, req_err;
    logic [3:0]  req_be;

    logic             cap_rd, cap_err;
    logic [IDX_W-1:0] cap_idx;
    logic [3:0]       cap_be;
    logic [31:0]      cap_wdata;

    logic        rsp_valid_q, rsp_err_q, rsp_rd_q;
    logic [3:0]  arr_we;
    logic [31:0] arr_rdata;

    // Offset is unsigned; the explicit lower-bound test keeps low addresses from wrapping in.
    assign offset   = data_addr - BASE_ADDR;
    assign in_range = (data_addr >= BASE_ADDR) && (offset < SPAN);

`ifdef MIPS_DMEM_SUBWORD_EN
    // Narrow write data is taken LSB-aligned and replicated across every lane.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = data_out;
        bad_align = 1'b0;
        case (req_size)
            SZ_BYTE: begin
                req_be    = 4'b1000 >> data_addr[1:0];
                req_wdata = {4{data_out[7:0]}};
            end
            SZ_HALF: begin
                req_be    = data_addr[1] ? 4'b0011 : 4'b1100;
                req_wdata = {2{data_out[15:0]}};
                bad_align = data_addr[0];
            end
            SZ_WORD: bad_align = |data_addr[1:0];
            default: bad_align = 1'b1;
        endcase
    end
`else
    logic unused_size;
    assign unused_size = ^req_size;
    assign req_be      = 4'b1111;
    assign req_wdata   = data_out;
    assign bad_align   = |data_addr[1:0];
`endif

    assign req_err   = !in_range || bad_align;
    assign req_ready = (state != ST_WAIT);
    assign accept    = req_valid && req_ready;
    assign fire      = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_rd    <= data_rd_wr;
            cap_err   <= req_err;
            cap_idx   <= offset[IDX_W+1:2];
            cap_be    <= req_be;
            cap_wdata <= req_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = ST_RESP;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                if (accept) begin
                    state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rsp_valid_q <= fire;
            rsp_err_q   <= fire && cap_err;
            rsp_rd_q    <= fire && cap_rd && !cap_err;
        end
    end

    // The access commits on the edge that closes the RESP cycle; reset there aborts it.
    assign arr_we = (fire && !cap_rd && !cap_err && !reset) ? cap_be : 4'b0000;

    mips_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .addr    (cap_idx),
        .byte_we (arr_we),
        .wdata   (cap_wdata),
        .rdata   (arr_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign data_in   = rsp_rd_q ? arr_rdata : 32'd0;

endmodule

`default_nettype wire

// File: doc/mips_data_mem.md
MIPS_DATA_MEM -- requirements
Module: mips_data_mem

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, byte address of the first mapped word.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, 16..65536.
REQ-003 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  processor presents a data access this cycle.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 data_rd_wr  input  1  1 = read, 0 = write; same polarity as the processor's output.
REQ-009 data_addr  input  32  byte address of the access.
REQ-010 data_out  input  32  write data from the processor; big-endian lanes, byte 0 in [31:24].
REQ-011 req_size  input  2  access size: 0 byte, 1 halfword, 2 word; 3 is illegal.
REQ-012 rsp_valid  output  1  one-cycle pulse marking response completion.
REQ-013 rsp_err  output  1  qualified by rsp_valid; access was rejected.
REQ-014 data_in  output  32  read data to the processor, qualified by rsp_valid.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready=1 in IDLE and RESP, 0 in WAIT.
REQ-016 Request accepted at edge E when req_valid && req_ready; rd_wr, addr, data_out and size are captured at E.
REQ-017 rsp_valid SHALL be high for exactly the one cycle following edge E+LATENCY; LATENCY=1 goes IDLE->RESP directly.
REQ-018 WAIT uses a 4-bit down-counter loaded with LATENCY-1 at E; RESP is entered when it reaches 0.
REQ-019 A request offered in RESP is accepted, giving back-to-back accesses with no idle cycle; otherwise RESP->IDLE.
REQ-020 Request is in error when address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), size is 3, a halfword has addr[0]=1, or a word has addr[1:0]!=0.
REQ-021 An error SHALL give rsp_err=1 and data_in=0, with no array write.
REQ-022 Read: data_in = full word at word index (addr-BASE_ADDR)>>2, sampled at edge E+LATENCY; size does not alter returned data.
REQ-023 Write: byte enables are derived from size and addr[1:0] (big-endian); committed at edge E+LATENCY; data_in=0.
REQ-024 Word index SHALL be computed in 32-bit unsigned arithmetic; addresses below BASE_ADDR SHALL NOT wrap into range.
REQ-025 req_valid while req_ready=0 SHALL be ignored; the processor must hold its request until accepted.
REQ-026 A read issued after a write to the same word SHALL return the written data.

Reset
REQ-027 Reset SHALL force IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_err=0, data_in=0.
REQ-028 Reset during WAIT or RESP SHALL abort the pending access: no write, no rsp_valid.
REQ-029 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro MIPS_DMEM_SUBWORD_EN defined: byte and halfword sizes are supported as in REQ-020/REQ-023.
REQ-031 Macro undefined: req_size is ignored, every access is a word access with full write enables, and only the range check and addr[1:0]!=0 raise errors.

Structure
REQ-032 Package mips_pkg SHALL hold the access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-033 Sub-module mips_dmem_array SHALL provide single-port synchronous storage with 4-bit byte write enables; FSM and decode live in mips_data_mem.

Verification (BASE_ADDR=0x1000_0000, DEPTH_WORDS=1024, LATENCY=2)
REQ-034 Word write 0xDEADBEEF @0x1000_0010, then read @0x1000_0010 -> rsp_valid 2 cycles after each accept, err=0, data_in=0xDEADBEEF.
REQ-035 Subword build: byte write 0xAA @0x1000_0021, then halfword write 0x1234 @0x1000_0022 over word 0 -> read @0x1000_0020 returns 0x00AA1234.
REQ-036 Read @0x0FFF_FFFC, read @0x1000_1000, and word read @0x1000_0002 -> each gives err=1, data_in=0; array unchanged.
REQ-037 Back-to-back: request held valid in RESP cycle -> accepted with no idle cycle; rsp_valid pulses exactly every 2 cycles.
REQ-038 Reset asserted in WAIT of a write 0x5555_5555 @0x1000_0040 -> no rsp_valid; later read @0x1000_0040 returns the prior value.
